// File: rtl/perf_counter_chain.sv
// perf_counter_chain: a chain of N_CH cycle counters.
// start launches channel 0. Each running channel counts clock edges until its monitored
// data word equals SENTINEL. The channel then stops in DONE, and the next channel starts
// counting from zero. A registered readback port returns the counter selected by sel.
// Optional build macro PERF_CNT_SAT_EN: counters saturate at all-ones instead of wrapping.
// The overflow flag is set in both builds.
module perf_counter_chain #(
   parameter int unsigned       N_CH     = 2,
   parameter int unsigned       CNT_W    = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter logic [DATA_W-1:0] SENTINEL = DATA_W'(32'h7fffffff),
   localparam int unsigned      SEL_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     clear,
   input  logic [N_CH*DATA_W-1:0]   rdata,
   input  logic [SEL_W-1:0]         sel,
   output logic [N_CH*CNT_W-1:0]    count_flat,
   output logic [CNT_W-1:0]         sel_count,
   output logic [N_CH-1:0]          busy,
   output logic [N_CH-1:0]          done,
   output logic [N_CH-1:0]          ovf,
   output logic                     all_done
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   state_e           state_q [N_CH];
   state_e           state_d [N_CH];
   logic [CNT_W-1:0] cnt_q   [N_CH];
   logic [CNT_W-1:0] cnt_d   [N_CH];
   logic [N_CH-1:0]  ovf_q, ovf_d;
   logic [CNT_W-1:0] sel_count_q, sel_count_d;

   logic [N_CH-1:0]  run_vec;
   logic [N_CH-1:0]  hit;
   // hit_prev[i] is set when channel i-1 stops this cycle, which hands the run to channel i.
   logic [N_CH:0]    hit_prev;
   logic             any_run;

   // Decode which channels are running and which of them see their sentinel this cycle.
   always_comb begin
      run_vec = '0;
      hit     = '0;
      for (int i = 0; i < N_CH; i++) begin
         run_vec[i] = (state_q[i] == StRun);
         hit[i]     = run_vec[i] && (rdata[i*DATA_W +: DATA_W] == SENTINEL);
      end
      any_run  = |run_vec;
      hit_prev = {hit, 1'b0};
   end

   // Next-state and counter update: clear beats start, and start beats normal running.
   always_comb begin
      ovf_d = ovf_q;
      for (int i = 0; i < N_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
      end

      if (clear) begin
         ovf_d = '0;
         for (int i = 0; i < N_CH; i++) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
         end
      end else if (start && !any_run) begin
         ovf_d = '0;
         for (int i = 0; i < N_CH; i++) begin
            state_d[i] = (i == 0) ? StRun : StIdle;
            cnt_d[i]   = '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (hit_prev[i]) begin
               // At most one channel runs at a time, so this channel is not in RUN itself.
               state_d[i] = StRun;
               cnt_d[i]   = '0;
            end else if (run_vec[i]) begin
               if (hit[i]) begin
                  // The counter holds on the stopping edge.
                  state_d[i] = StDone;
               end else if (&cnt_q[i]) begin
                  ovf_d[i] = 1'b1;
`ifdef PERF_CNT_SAT_EN
                  cnt_d[i] = cnt_q[i];
`else
                  cnt_d[i] = '0;
`endif
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
         end
      end
   end

   // Readback mux. An out-of-range sel matches no channel, so it reads as zero.
   always_comb begin
      sel_count_d = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (sel == SEL_W'(i)) begin
            sel_count_d = cnt_q[i];
         end
      end
   end

   // State registers. Reset is asynchronous, so every output drops at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= StIdle;
            cnt_q[i]   <= '0;
         end
         ovf_q       <= '0;
         sel_count_q <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         ovf_q       <= ovf_d;
         sel_count_q <= sel_count_d;
      end
   end

   // Flatten per-channel state into the output buses.
   always_comb begin
      count_flat = '0;
      busy       = '0;
      done       = '0;
      for (int i = 0; i < N_CH; i++) begin
         count_flat[i*CNT_W +: CNT_W] = cnt_q[i];
         busy[i]                      = (state_q[i] == StRun);
         done[i]                      = (state_q[i] == StDone);
      end
   end

   assign ovf       = ovf_q;
   assign all_done  = (state_q[N_CH-1] == StDone);
   assign sel_count = sel_count_q;

endmodule

// File: tb/tb_perf_counter_chain.sv
// Self-checking bench for perf_counter_chain, built with three channels and 4-bit counters
// so that counter overflow is reachable. Define PERF_CNT_SAT_EN for both DUT and bench to
// check the saturating build.
module tb_perf_counter_chain;

   localparam int unsigned N_CH   = 3;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DATA_W = 8;
   localparam logic [DATA_W-1:0] SENT = 8'hA5;
   localparam int unsigned SEL_W  = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;
   localparam int OBS_W = N_CH*CNT_W + 3*N_CH + 1 + CNT_W;
`ifdef PERF_CNT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   start;
   logic                   clear;
   logic [N_CH*DATA_W-1:0] rdata;
   logic [SEL_W-1:0]       sel;
   logic [N_CH*CNT_W-1:0]  count_flat;
   logic [CNT_W-1:0]       sel_count;
   logic [N_CH-1:0]        busy;
   logic [N_CH-1:0]        done;
   logic [N_CH-1:0]        ovf;
   logic                   all_done;

   int n_checks = 0;
   int n_fail   = 0;

   perf_counter_chain #(
      .N_CH     (N_CH),
      .CNT_W    (CNT_W),
      .DATA_W   (DATA_W),
      .SENTINEL (SENT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .clear      (clear),
      .rdata      (rdata),
      .sel        (sel),
      .count_flat (count_flat),
      .sel_count  (sel_count),
      .busy       (busy),
      .done       (done),
      .ovf        (ovf),
      .all_done   (all_done)
   );

   always #5 clk = ~clk;

   // Reference model: channel phase 0=idle, 1=run, 2=done, with integer counts.
   int m_st  [N_CH];
   int m_cnt [N_CH];
   bit m_ovf [N_CH];
   int m_sel;

   function automatic void model_reset();
      for (int i = 0; i < N_CH; i++) begin
         m_st[i]  = 0;
         m_cnt[i] = 0;
         m_ovf[i] = 1'b0;
      end
      m_sel = 0;
   endfunction

   // Advance the model by one rising edge, using the inputs that the DUT sampled.
   function automatic void model_step();
      int  nst [N_CH];
      int  ncnt[N_CH];
      bit  novf[N_CH];
      bit  running;
      logic [DATA_W-1:0] w;
      if (!reset) begin
         model_reset();
         return;
      end
      running = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         nst[i]  = m_st[i];
         ncnt[i] = m_cnt[i];
         novf[i] = m_ovf[i];
         if (m_st[i] == 1) running = 1'b1;
      end
      m_sel = (int'(sel) < N_CH) ? m_cnt[sel] : 0;
      if (clear) begin
         for (int i = 0; i < N_CH; i++) begin
            nst[i] = 0; ncnt[i] = 0; novf[i] = 1'b0;
         end
      end else if (start && !running) begin
         for (int i = 0; i < N_CH; i++) begin
            nst[i] = (i == 0) ? 1 : 0; ncnt[i] = 0; novf[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (m_st[i] == 1) begin
               w = rdata[i*DATA_W +: DATA_W];
               if (w == SENT) begin
                  nst[i] = 2;
                  if (i + 1 < N_CH) begin
                     nst[i+1] = 1; ncnt[i+1] = 0;
                  end
               end else if (m_cnt[i] == CMAX) begin
                  novf[i] = 1'b1;
                  ncnt[i] = SAT ? CMAX : 0;
               end else begin
                  ncnt[i] = m_cnt[i] + 1;
               end
            end
         end
      end
      for (int i = 0; i < N_CH; i++) begin
         m_st[i] = nst[i]; m_cnt[i] = ncnt[i]; m_ovf[i] = novf[i];
      end
   endfunction

   function automatic logic [OBS_W-1:0] exp_obs();
      logic [N_CH*CNT_W-1:0] ec;
      logic [N_CH-1:0]       eb, ed, eo;
      for (int i = 0; i < N_CH; i++) begin
         ec[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
         eb[i] = (m_st[i] == 1);
         ed[i] = (m_st[i] == 2);
         eo[i] = m_ovf[i];
      end
      return {ec, eb, ed, eo, (m_st[N_CH-1] == 2), CNT_W'(m_sel)};
   endfunction

   function automatic logic [OBS_W-1:0] obs();
      return {count_flat, busy, done, ovf, all_done, sel_count};
   endfunction

   function automatic logic [DATA_W-1:0] nonsent();
      logic [DATA_W-1:0] w;
      w = DATA_W'($urandom);
      if (w == SENT) w = w + 1'b1;
      return w;
   endfunction

   // Drive the running channel's word, either sentinel or not; the other words are random.
   task automatic drive_words(input int run_ch, input bit sent);
      for (int i = 0; i < N_CH; i++) begin
         if (i == run_ch) rdata[i*DATA_W +: DATA_W] = sent ? SENT : nonsent();
         else rdata[i*DATA_W +: DATA_W] = ($urandom_range(3) == 0) ? SENT : nonsent();
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; clear = 1'b0; sel = '0;
      drive_words(-1, 1'b0);
      model_reset();
      #1;
      n_checks++;
      if (obs() !== '0) begin
         n_fail++; $display("FAIL reset_async: got %h expected 0", obs());
      end
      for (int k = 0; k < 3; k++) begin
         start = 1'b1;
         tick();
         n_checks++;
         if (obs() !== exp_obs()) begin
            n_fail++; $display("FAIL reset_hold: got %h expected %h", obs(), exp_obs());
         end
      end
      start = 1'b0;
      reset = 1'b1;
   endtask

   task automatic test_chain();
      int lens[N_CH] = '{10, 5, 3};
      do_clear();
      start = 1'b1;
      drive_words(0, 1'b0);
      tick();
      start = 1'b0;
      for (int ch = 0; ch < N_CH; ch++) begin
         for (int k = 0; k < lens[ch]; k++) begin
            drive_words(ch, 1'b0);
            tick();
            n_checks++;
            if (obs() !== exp_obs()) begin
               n_fail++; $display("FAIL chain_run: got %h expected %h", obs(), exp_obs());
            end
         end
         drive_words(ch, 1'b1);
         tick();
         n_checks++;
         if (obs() !== exp_obs()) begin
            n_fail++; $display("FAIL chain_stop: got %h expected %h", obs(), exp_obs());
         end
      end
      n_checks++;
      if (count_flat !== 12'h35A) begin
         n_fail++; $display("FAIL chain_counts: got %h expected 35a", count_flat);
      end
      n_checks++;
      if ({all_done, busy, done} !== 7'b1_000_111) begin
         n_fail++; $display("FAIL chain_flags: got %b expected 1000111", {all_done, busy, done});
      end
   endtask

   task automatic test_first_sentinel();
      do_clear();
      start = 1'b1;
      drive_words(0, 1'b1);
      tick();
      start = 1'b0;
      n_checks++;
      if ({busy[0], done[0]} !== 2'b10) begin
         n_fail++; $display("FAIL first_enter: got %b expected 10", {busy[0], done[0]});
      end
      drive_words(0, 1'b1);
      tick();
      n_checks++;
      if ({done[0], busy[1], count_flat[3:0]} !== 6'b11_0000) begin
         n_fail++;
         $display("FAIL first_stop: got %b expected 110000", {done[0], busy[1], count_flat[3:0]});
      end
      n_checks++;
      if (obs() !== exp_obs()) begin
         n_fail++; $display("FAIL first_model: got %h expected %h", obs(), exp_obs());
      end
   endtask

   task automatic test_overflow();
      logic [CNT_W-1:0] want;
      want = SAT ? 4'd15 : 4'd4;
      do_clear();
      start = 1'b1;
      drive_words(0, 1'b0);
      tick();
      start = 1'b0;
      for (int k = 0; k < 20; k++) begin
         drive_words(0, 1'b0);
         tick();
         n_checks++;
         if (obs() !== exp_obs()) begin
            n_fail++; $display("FAIL ovf_run: got %h expected %h", obs(), exp_obs());
         end
      end
      n_checks++;
      if ({ovf[0], count_flat[3:0]} !== {1'b1, want}) begin
         n_fail++;
         $display("FAIL ovf_final: got %b expected %b", {ovf[0], count_flat[3:0]}, {1'b1, want});
      end
      do_clear();
      n_checks++;
      if ({ovf, busy, count_flat} !== '0) begin
         n_fail++; $display("FAIL ovf_clear: got %h expected 0", {ovf, busy, count_flat});
      end
   endtask

   task automatic test_start_ignored();
      do_clear();
      start = 1'b1;
      drive_words(0, 1'b0);
      tick();
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         drive_words(0, 1'b0);
         tick();
      end
      drive_words(0, 1'b1);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive_words(1, 1'b0);
         tick();
      end
      start = 1'b1;
      drive_words(1, 1'b0);
      tick();
      start = 1'b0;
      n_checks++;
      if ({busy, count_flat} !== {3'b010, 12'h042}) begin
         n_fail++; $display("FAIL start_ignored: got %h expected 2042", {busy, count_flat});
      end
      clear = 1'b1;
      start = 1'b1;
      tick();
      clear = 1'b0;
      start = 1'b0;
      n_checks++;
      if ({all_done, busy, done, count_flat} !== '0) begin
         n_fail++;
         $display("FAIL clear_over_start: got %h expected 0", {all_done, busy, done, count_flat});
      end
      n_checks++;
      if (obs() !== exp_obs()) begin
         n_fail++; $display("FAIL clear_model: got %h expected %h", obs(), exp_obs());
      end
   endtask

   task automatic test_async_reset();
      do_clear();
      start = 1'b1;
      drive_words(0, 1'b0);
      tick();
      start = 1'b0;
      sel = 2'd0;
      for (int k = 0; k < 4; k++) begin
         drive_words(0, 1'b0);
         tick();
      end
      #3;
      reset = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (obs() !== '0) begin
         n_fail++; $display("FAIL reset_mid_run: got %h expected 0", obs());
      end
      tick();
      tick();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive_words(0, 1'b0);
         tick();
         n_checks++;
         if (busy !== 3'b000) begin
            n_fail++; $display("FAIL reset_needs_start: got busy %b expected 000", busy);
         end
      end
      start = 1'b1;
      drive_words(0, 1'b0);
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive_words(0, 1'b0);
         tick();
      end
      drive_words(0, 1'b1);
      tick();
      for (int k = 0; k < 6; k++) begin
         drive_words(1, 1'b0);
         tick();
      end
      sel = 2'd1;
      drive_words(1, 1'b1);
      tick();
      n_checks++;
      if (sel_count !== 4'd6) begin
         n_fail++; $display("FAIL sel_readback: got %0d expected 6", sel_count);
      end
      sel = 2'd3;
      drive_words(2, 1'b0);
      tick();
      n_checks++;
      if (sel_count !== 4'd0) begin
         n_fail++; $display("FAIL sel_out_of_range: got %0d expected 0", sel_count);
      end
      sel = 2'd2;
      drive_words(2, 1'b0);
      tick();
      n_checks++;
      if (obs() !== exp_obs()) begin
         n_fail++; $display("FAIL sel_model: got %h expected %h", obs(), exp_obs());
      end
   endtask

   task automatic test_random();
      int rate;
      for (int k = 0; k < 800; k++) begin
         rate  = (k < 400) ? 4 : 24;
         start = ($urandom_range(7) == 0);
         clear = ($urandom_range(60) == 0);
         sel   = SEL_W'($urandom);
         for (int i = 0; i < N_CH; i++) begin
            rdata[i*DATA_W +: DATA_W] = ($urandom_range(rate) == 0) ? SENT : nonsent();
         end
         tick();
         n_checks++;
         if (obs() !== exp_obs()) begin
            n_fail++; $display("FAIL random_cycle %0d: got %h expected %h", k, obs(), exp_obs());
         end
      end
      start = 1'b0;
      clear = 1'b0;
   endtask

   initial begin
      test_reset();
      test_chain();
      test_first_sentinel();
      test_overflow();
      test_start_ignored();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/perf_counter_chain.md
PERF_COUNTER_CHAIN -- requirements
Module: perf_counter_chain

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of chained channels, range 1..16.
REQ-002 SHALL have parameter CNT_W, default 32: counter width per channel.
REQ-003 SHALL have parameter DATA_W, default 32: width of each monitored data word.
REQ-004 SHALL have parameter SENTINEL, default 32'h7fffffff: stop value, DATA_W bits.
REQ-005 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  in  1  synchronous pulse; launches channel 0.
REQ-008 SHALL have port clear  in  1  synchronous; returns all channels to IDLE.
REQ-009 SHALL have port rdata  in  N_CH*DATA_W  monitored words; channel i at [i*DATA_W +: DATA_W].
REQ-010 SHALL have port sel  in  max(1,clog2(N_CH))  readback channel index.
REQ-011 SHALL have port count_flat  out  N_CH*CNT_W  live counters; channel i at [i*CNT_W +: CNT_W].
REQ-012 SHALL have port sel_count  out  CNT_W  registered copy of the counter selected by sel.
REQ-013 SHALL have ports busy, done, ovf  out  N_CH each  per-channel RUN state, DONE state, sticky overflow.
REQ-014 SHALL have port all_done  out  1  high while channel N_CH-1 is in DONE.

Function
REQ-015 Each channel SHALL run an FSM with states IDLE, RUN, DONE; busy[i]=RUN, done[i]=DONE.
REQ-016 clear=1 SHALL force every channel to IDLE, zero every counter and ovf bit; clear has priority over start and all other events.
REQ-017 start=1 while no channel is in RUN SHALL: zero all counters and ovf bits, put channel 0 in RUN, all others in IDLE.
REQ-018 start=1 while any channel is in RUN SHALL be ignored with no state change.
REQ-019 A channel in RUN whose rdata word equals SENTINEL in cycle t SHALL enter DONE at the edge ending cycle t, counter held (not incremented at that edge).
REQ-020 At that same edge, channel i+1 (if present) SHALL enter RUN with counter 0; channel N_CH-1 entering DONE SHALL raise all_done.
REQ-021 A channel in RUN without sentinel SHALL increment its counter by 1 per edge; count therefore equals edges spent in RUN before stop (0 if sentinel in first RUN cycle).
REQ-022 rdata of a channel in IDLE or DONE SHALL be ignored; a sentinel in the cycle a channel is entering RUN SHALL not be seen until the following cycle.
REQ-023 Counters in IDLE and DONE SHALL hold their value.
REQ-024 An increment from all-ones SHALL set ovf[i], which stays set until start, clear or reset.
REQ-025 sel_count SHALL equal count of channel sel one edge earlier (1-cycle latency); sel >= N_CH SHALL give 0.

Reset
REQ-026 reset=0 SHALL immediately, without clock, force all channels to IDLE and all counters, ovf, done, busy, all_done and sel_count to 0.
REQ-027 Reset mid-operation SHALL discard all progress; first post-reset activity requires a new start.

Configuration
REQ-028 With macro PERF_CNT_SAT_EN defined, a counter at all-ones SHALL saturate and hold while in RUN, ovf[i] set.
REQ-029 Without PERF_CNT_SAT_EN, a counter SHALL wrap from all-ones to 0, ovf[i] set identically.

Verification
REQ-030 N_CH=2: start pulse, sentinel on ch0 after 10 RUN cycles, ch1 after 5 more -> count0=10, count1=5, all_done=1, busy=0.
REQ-031 Sentinel on ch0 already present in its first RUN cycle -> count0=0, done[0]=1, ch1 in RUN next cycle.
REQ-032 CNT_W=4, 20 RUN cycles -> with PERF_CNT_SAT_EN count=15; without count=4; ovf[0]=1 in both.
REQ-033 start re-pulsed while ch1 in RUN at count 3 -> ignored, ch1 continues to 4; clear asserted together with start -> all IDLE, counts 0.
REQ-034 reset driven low mid-RUN between clock edges -> all outputs 0 immediately; sel=1 readback after next run returns count1 one cycle after sel change.
